// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: idle level, clean stop, burst mode, edge strobes.
// Optional CLKDIV_DUTY_EN adds lead_cycles to set the leading-half length separately.
module clock_divider_prog #(
    parameter int CNT_W      = 16,
    parameter int BURST_W    = 8,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [CNT_W-1:0]   half_period,
    input  logic [BURST_W-1:0] burst_len,
`ifdef CLKDIV_DUTY_EN
    input  logic [CNT_W-1:0]   lead_cycles,
`endif
    output logic               div_clk,
    output logic               lead_stb,
    output logic               trail_stb,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_LOW} state_t;

    localparam logic [CNT_W-1:0]   C_ONE = CNT_W'(1);
    localparam logic [BURST_W-1:0] B_ONE = BURST_W'(1);

    state_t             r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [CNT_W-1:0]   r_hp, w_hp_nx;
    logic [CNT_W-1:0]   r_lead, w_lead_nx;
    logic [BURST_W-1:0] r_bl, w_bl_nx;
    logic [BURST_W-1:0] r_pcnt, w_pcnt_nx;
    logic               r_phase, w_phase_nx;
    logic               r_div, w_div_nx;
    logic               r_lstb, w_lstb_nx;
    logic               r_tstb, w_tstb_nx;
    logic               r_busy, w_busy_nx;
    logic               r_done, w_done_nx;

    logic [CNT_W-1:0]   w_hp_in;
    logic [CNT_W-1:0]   w_lead_in;
    logic [CNT_W-1:0]   w_len;
    logic               w_bnd;
    logic               w_lead_bnd;
    logic               w_trail_bnd;
    logic               w_burst_end;

    assign w_hp_in = (half_period == '0) ? C_ONE : half_period;
`ifdef CLKDIV_DUTY_EN
    assign w_lead_in = (lead_cycles == '0) ? C_ONE : lead_cycles;
`else
    assign w_lead_in = w_hp_in;
`endif

    // r_phase=1 while in the leading (non-idle) half
    assign w_len       = r_phase ? r_lead : r_hp;
    assign w_bnd       = (r_state == S_RUN) && (r_cnt == w_len - C_ONE);
    assign w_lead_bnd  = w_bnd && r_phase;
    assign w_trail_bnd = w_bnd && !r_phase;
    assign w_burst_end = w_trail_bnd && (r_bl != '0) && (r_pcnt == r_bl);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hp    <= '0;
            r_lead  <= '0;
            r_bl    <= '0;
            r_pcnt  <= '0;
            r_phase <= 1'b0;
            r_div   <= IDLE_LEVEL;
            r_lstb  <= 1'b0;
            r_tstb  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hp    <= w_hp_nx;
            r_lead  <= w_lead_nx;
            r_bl    <= w_bl_nx;
            r_pcnt  <= w_pcnt_nx;
            r_phase <= w_phase_nx;
            r_div   <= w_div_nx;
            r_lstb  <= w_lstb_nx;
            r_tstb  <= w_tstb_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (enable) w_state_nx = S_RUN;
            end
            S_RUN: begin
                if (w_burst_end)
                    w_state_nx = enable ? S_WAIT_LOW : S_IDLE;
                else if (w_trail_bnd && !enable)
                    w_state_nx = S_IDLE;
            end
            S_WAIT_LOW: begin
                if (!enable) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nx   = r_cnt;
        w_hp_nx    = r_hp;
        w_lead_nx  = r_lead;
        w_bl_nx    = r_bl;
        w_pcnt_nx  = r_pcnt;
        w_phase_nx = r_phase;
        w_div_nx   = r_div;
        w_busy_nx  = r_busy;
        w_lstb_nx  = 1'b0;
        w_tstb_nx  = 1'b0;
        w_done_nx  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_hp_nx    = w_hp_in;
                    w_lead_nx  = w_lead_in;
                    w_bl_nx    = burst_len;
                    w_cnt_nx   = '0;
                    w_pcnt_nx  = '0;
                    w_phase_nx = 1'b1;
                    w_div_nx   = ~IDLE_LEVEL;
                    w_lstb_nx  = 1'b1;
                    w_busy_nx  = 1'b1;
                end
            end
            S_RUN: begin
                w_cnt_nx = w_bnd ? '0 : r_cnt + C_ONE;
                if (w_lead_bnd) begin
                    w_div_nx   = IDLE_LEVEL;
                    w_tstb_nx  = 1'b1;
                    w_phase_nx = 1'b0;
                    if (r_bl != '0) w_pcnt_nx = r_pcnt + B_ONE;
                end else if (w_trail_bnd) begin
                    if (w_burst_end) begin
                        w_busy_nx = 1'b0;
                        w_done_nx = 1'b1;
                    end else if (!enable) begin
                        w_busy_nx = 1'b0;
                    end else begin
                        w_div_nx   = ~IDLE_LEVEL;
                        w_lstb_nx  = 1'b1;
                        w_phase_nx = 1'b1;
                    end
                end
            end
            S_WAIT_LOW: begin
                w_div_nx = IDLE_LEVEL;
            end
            default: begin
                w_div_nx  = IDLE_LEVEL;
                w_busy_nx = 1'b0;
            end
        endcase
    end

    assign div_clk   = r_div;
    assign lead_stb  = r_lstb;
    assign trail_stb = r_tstb;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Scoreboard bench for clock_divider_prog: two instances (idle low / idle high).
// Define CLKDIV_DUTY_EN to also exercise the separate leading-half length.
module tb_clock_divider_prog;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en0, en1;
    logic [15:0] half_period;
    logic [7:0]  burst_len;
`ifdef CLKDIV_DUTY_EN
    logic [15:0] lead_cycles;
`endif
    logic d0, l0, t0, b0, n0;
    logic d1, l1, t1, b1, n1;

    int checks   = 0;
    int failures = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    clock_divider_prog #(.CNT_W(16), .BURST_W(8), .IDLE_LEVEL(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(en0),
        .half_period(half_period), .burst_len(burst_len),
`ifdef CLKDIV_DUTY_EN
        .lead_cycles(lead_cycles),
`endif
        .div_clk(d0), .lead_stb(l0), .trail_stb(t0), .busy(b0), .done(n0)
    );

    clock_divider_prog #(.CNT_W(16), .BURST_W(8), .IDLE_LEVEL(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en1),
        .half_period(half_period), .burst_len(burst_len),
`ifdef CLKDIV_DUTY_EN
        .lead_cycles(lead_cycles),
`endif
        .div_clk(d1), .lead_stb(l1), .trail_stb(t1), .busy(b1), .done(n1)
    );

    // Expected {div,lead,trail,busy,done} k cycles after a start edge (idle low)
    function automatic logic [4:0] fr(int k, int lh, int th);
        int m;
        m = k % (lh + th);
        return {m < lh, m == 0, m == lh, 1'b1, 1'b0};
    endfunction

    function automatic logic [4:0] burst_exp(int j);
        if (j < 16) return fr(j, 4, 4);
        if (j == 16) return 5'b00001;
        return 5'b00000;
    endfunction

    task automatic test_reset();
        logic [4:0] e, o;
        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
        half_period = 16'd3; burst_len = 8'd0;
`ifdef CLKDIV_DUTY_EN
        lead_cycles = 16'd0;
`endif
        exp_q.push_back(5'b00000);
        exp_q.push_back(5'b10000);
        repeat (2) @(posedge clk);
        #1;
        e = exp_q.pop_front(); o = {d0, l0, t0, b0, n0}; checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_u0 got=%b exp=%b", o, e);
        end
        e = exp_q.pop_front(); o = {d1, l1, t1, b1, n1}; checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_u1 got=%b exp=%b", o, e);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        logic [4:0] e, o;
        half_period = 16'd3; burst_len = 8'd0; en0 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 18) en0 = 1'b0;
            exp_q.push_back(k < 18 ? fr(k, 3, 3) : 5'b00000);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {d0, l0, t0, b0, n0}; checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL free_run k=%0d got=%b exp=%b", k, o, e);
            end
        end
    endtask

    task automatic test_burst();
        logic [4:0] e, o;
        half_period = 16'd4; burst_len = 8'd2; en0 = 1'b1;
        for (int k = 0; k < 21; k++) begin
            if (k == 20) en0 = 1'b0;
            exp_q.push_back(burst_exp(k));
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {d0, l0, t0, b0, n0}; checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL burst k=%0d got=%b exp=%b", k, o, e);
            end
        end
        en0 = 1'b1;
        for (int j = 0; j < 19; j++) begin
            if (j == 18) en0 = 1'b0;
            exp_q.push_back(burst_exp(j));
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {d0, l0, t0, b0, n0}; checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL burst_restart j=%0d got=%b exp=%b", j, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e, o;
        half_period = 16'd2; burst_len = 8'd0; en0 = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 8 || k == 11) en0 = 1'b0;
            if (k == 9) en0 = 1'b1;
            if (k < 8) e = fr(k, 2, 2);
            else if (k == 8 || k == 13) e = 5'b00000;
            else e = fr(k - 9, 2, 2);
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {d0, l0, t0, b0, n0}; checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL back_to_back k=%0d got=%b exp=%b", k, o, e);
            end
        end
    endtask

    task automatic test_stop_mid();
        logic [4:0] e, o;
        half_period = 16'd5; burst_len = 8'd0; en0 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) en0 = 1'b0;
            exp_q.push_back(k < 10 ? fr(k, 5, 5) : 5'b00000);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {d0, l0, t0, b0, n0}; checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stop_mid k=%0d got=%b exp=%b", k, o, e);
            end
        end
    endtask

    task automatic test_hp_change_reset();
        logic [4:0] e, o;
        half_period = 16'd3; burst_len = 8'd0; en0 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) half_period = 16'd7;
            exp_q.push_back(fr(k, 3, 3));
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {d0, l0, t0, b0, n0}; checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL hp_change k=%0d got=%b exp=%b", k, o, e);
            end
        end
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                rst_n = 1'b1; en0 = 1'b0;
            end
            exp_q.push_back(5'b00000);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {d0, l0, t0, b0, n0}; checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL mid_reset k=%0d got=%b exp=%b", k, o, e);
            end
        end
    endtask

    task automatic test_idle_high();
        logic [4:0] e, o;
        half_period = 16'd0; burst_len = 8'd0; en1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) en1 = 1'b0;
            if (k < 8) e = {k % 2 == 1, k % 2 == 0, k % 2 == 1, 1'b1, 1'b0};
            else e = 5'b10000;
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {d1, l1, t1, b1, n1}; checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL idle_high k=%0d got=%b exp=%b", k, o, e);
            end
        end
    endtask

`ifdef CLKDIV_DUTY_EN
    task automatic test_duty();
        logic [4:0] e, o;
        half_period = 16'd6; lead_cycles = 16'd2; burst_len = 8'd0; en0 = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (k == 16) en0 = 1'b0;
            exp_q.push_back(k < 16 ? fr(k, 2, 6) : 5'b00000);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = {d0, l0, t0, b0, n0}; checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL duty k=%0d got=%b exp=%b", k, o, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_burst();
        test_back_to_back();
        test_stop_mid();
        test_hp_change_reset();
        test_idle_high();
`ifdef CLKDIV_DUTY_EN
        test_duty();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
